// File: rtl/ror_pkg.sv
// Shared constants and sizing helpers for the ROR outlier path.
package ror_pkg;

    localparam int INDEX_W = 16;

    // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // FIFO pointers carry one wrap bit above the address bits.
    function automatic int fifo_ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Width of a core-select value; never zero, even for one core.
    function automatic int sel_w(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter
    import ror_pkg::*;
#(
    parameter int CORE_NUMBER = 2,
    localparam int SW = sel_w(CORE_NUMBER)
) (
    input  logic [CORE_NUMBER-1:0] req,
    input  logic [SW-1:0]          ptr,
    input  logic                   enable,
    output logic [CORE_NUMBER-1:0] grant,
    output logic [SW-1:0]          grant_idx
);

    // Scan requesters starting at ptr; the first one hit wins.
    always_comb begin
        logic          found;
        logic [SW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < CORE_NUMBER; k++) begin
            idx = SW'((int'(ptr) + k) % CORE_NUMBER);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/outlier_collector.sv
// Collects outlier indices from parallel cores into a FWFT FIFO for the host.
module outlier_collector
    import ror_pkg::*;
#(
    parameter int CORE_NUMBER = 2,
    parameter int N           = INDEX_W,
    parameter int FIFO_DEPTH  = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CORE_NUMBER-1:0]   core_valid,
    input  logic [N*CORE_NUMBER-1:0] core_index,
    output logic [CORE_NUMBER-1:0]   core_ready,
    input  logic                     scan_done,
    input  logic                     read_fifo,
    output logic [N-1:0]             outlier_pos_fifo,
    output logic                     empty,
    output logic                     full,
    output logic [N-1:0]             outlier_count,
    output logic                     done
);

    localparam int AW   = clog2(FIFO_DEPTH);
    localparam int PTRW = fifo_ptr_w(FIFO_DEPTH);
    localparam int SW   = sel_w(CORE_NUMBER);

    logic [SW-1:0]   ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [N-1:0]    mem [FIFO_DEPTH];
    logic            scan_seen;

    logic            can_write;
    logic            push;
    logic            pop;
    logic [SW-1:0]   grant_idx;
    logic [N-1:0]    index_in;

    // Status flags come only from registered pointers.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign can_write = !full || (read_fifo && !empty);
    assign pop       = read_fifo && !empty;
    assign push      = |core_ready;
    assign index_in  = core_index[int'(grant_idx)*N +: N];

    // Head is forced to zero while empty so stale entries never show.
    assign outlier_pos_fifo = empty ? '0 : mem[rd_ptr[AW-1:0]];

    rr_arbiter #(
        .CORE_NUMBER(CORE_NUMBER)
    ) u_arb (
        .req      (core_valid),
        .ptr      (ptr),
        .enable   (can_write && !reset),
        .grant    (core_ready),
        .grant_idx(grant_idx)
    );

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[AW-1:0]] <= index_in;
    end

    // Pointers, arbitration state, frame counters and completion flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr           <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outlier_count <= '0;
            scan_seen     <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                ptr    <= SW'((int'(grant_idx) + 1) % CORE_NUMBER);
                if (outlier_count != '1) outlier_count <= outlier_count + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (scan_done) scan_seen <= 1'b1;
            // Once set, late indices must not pull done back down.
            done <= done || (scan_seen && (core_valid == '0));
        end
    end

endmodule

// File: tb/tb_outlier_collector.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_outlier_collector;

    localparam int CN    = 2;
    localparam int NW    = 16;
    localparam int DEPTH = 64;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic [CN-1:0]     core_valid;
    logic [NW*CN-1:0]  core_index;
    logic [CN-1:0]     core_ready;
    logic              scan_done;
    logic              read_fifo;
    logic [NW-1:0]     outlier_pos_fifo;
    logic              empty;
    logic              full;
    logic [NW-1:0]     outlier_count;
    logic              done;

    outlier_collector #(.CORE_NUMBER(CN), .N(NW), .FIFO_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .core_valid      (core_valid),
        .core_index      (core_index),
        .core_ready      (core_ready),
        .scan_done       (scan_done),
        .read_fifo       (read_fifo),
        .outlier_pos_fifo(outlier_pos_fifo),
        .empty           (empty),
        .full            (full),
        .outlier_count   (outlier_count),
        .done            (done)
    );

    // Four-core instance for the wrap-around arbitration case.
    logic          reset4;
    logic [3:0]    valid4;
    logic [63:0]   index4;
    logic [3:0]    ready4;
    logic [15:0]   head4;
    logic          empty4;
    logic          full4;
    logic [15:0]   count4;
    logic          done4;

    outlier_collector #(.CORE_NUMBER(4), .N(16), .FIFO_DEPTH(8)) dut4 (
        .clock           (clock),
        .reset           (reset4),
        .core_valid      (valid4),
        .core_index      (index4),
        .core_ready      (ready4),
        .scan_done       (1'b0),
        .read_fifo       (1'b0),
        .outlier_pos_fifo(head4),
        .empty           (empty4),
        .full            (full4),
        .outlier_count   (count4),
        .done            (done4)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [NW-1:0] q[$];
    int            mptr;
    int            mcount;
    bit            mseen;
    bit            mdone;
    logic [CN-1:0] exp_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which core the rules say should be granted this cycle.
    function automatic logic [CN-1:0] model_grant();
        logic [CN-1:0] g;
        bit            canw;
        int            c;
        g    = '0;
        canw = (q.size() < DEPTH) || (read_fifo && q.size() > 0);
        if (reset || !canw) return g;
        for (int k = 0; k < CN; k++) begin
            c = (mptr + k) % CN;
            if (core_valid[c]) begin
                g[c] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    // Check all outputs mid-cycle, then advance the model across the edge.
    task automatic cycle();
        @(negedge clock);
        exp_ready = model_grant();
        chk("ready", core_ready, exp_ready);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("head", outlier_pos_fifo, (q.size() > 0) ? q[0] : 16'h0);
        chk("count", outlier_count, mcount);
        chk("done", done, mdone);
        if (reset) begin
            q.delete();
            mptr = 0; mcount = 0; mseen = 0; mdone = 0;
        end else begin
            if (read_fifo && q.size() > 0) void'(q.pop_front());
            for (int c = 0; c < CN; c++) begin
                if (exp_ready[c]) begin
                    q.push_back(core_index[NW*c +: NW]);
                    mptr = (c + 1) % CN;
                    if (mcount < 65535) mcount++;
                end
            end
            mdone = mdone || (mseen && core_valid == '0);
            mseen = mseen || scan_done;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        reset = 1'b1; core_valid = '0; core_index = '0; scan_done = 1'b0; read_fifo = 1'b0;
        reset4 = 1'b1; valid4 = '0; index4 = '0;
        exp_ready = '0;
        q.delete(); mptr = 0; mcount = 0; mseen = 0; mdone = 0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, then a single accept from core 0.
        cycle();
        reset = 1'b0;
        cycle();
        chk("rst_empty", empty, 1'b1);
        core_valid = 2'b01; core_index = {16'h0000, 16'h0005};
        cycle();
        chk("t1_ready", exp_ready, 2'b01);
        core_valid = '0;
        cycle();
        chk("t1_head", outlier_pos_fifo, 16'h0005);
        chk("t1_count", outlier_count, 16'd1);

        // Fill to full with alternating grants.
        reset = 1'b1; cycle(); reset = 1'b0;
        core_valid = 2'b11; core_index = {16'h0020, 16'h0010};
        for (int i = 0; i < 66; i++) cycle();
        chk("fill_full", full, 1'b1);
        chk("fill_count", outlier_count, 16'd64);
        chk("fill_head", outlier_pos_fifo, 16'h0010);

        // Push and pop together while full.
        read_fifo = 1'b1; core_valid = 2'b10;
        cycle();
        read_fifo = 1'b0; core_valid = 2'b01;
        cycle();
        chk("pp_full", full, 1'b1);
        chk("pp_count", outlier_count, 16'd65);

        // done waits for core_valid to drop after scan_done.
        scan_done = 1'b1; cycle(); scan_done = 1'b0;
        cycle(); cycle();
        chk("done_held_low", done, 1'b0);
        core_valid = '0;
        cycle(); cycle();
        chk("done_high", done, 1'b1);
        read_fifo = 1'b1;
        n = 0;
        while (!empty && n < 80) begin cycle(); n++; end
        chk("drain_bound", n < 80, 1'b1);
        cycle(); cycle();
        chk("drain_empty", empty, 1'b1);
        chk("drain_done", done, 1'b1);
        read_fifo = 1'b0;

        // Reset with entries queued and ptr on core 1.
        reset = 1'b1; cycle(); reset = 1'b0;
        core_valid = 2'b11; core_index = {16'h0BBB, 16'h0AAA};
        for (int i = 0; i < 9; i++) cycle();
        core_valid = 2'b01;
        cycle();
        core_valid = '0;
        reset = 1'b1; cycle(); reset = 1'b0;
        chk("rr_empty", empty, 1'b1);
        chk("rr_count", outlier_count, 16'd0);
        core_valid = 2'b11;
        cycle();
        chk("rr_first", exp_ready, 2'b01);

        // Random traffic; cores hold their request until accepted.
        core_valid = '0;
        for (int i = 0; i < 2500; i++) begin
            for (int c = 0; c < CN; c++) begin
                if (!core_valid[c] || exp_ready[c]) begin
                    core_valid[c] = ($urandom_range(0, 2) != 0);
                    core_index[NW*c +: NW] = NW'($urandom);
                end
            end
            read_fifo = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            scan_done = ($urandom_range(0, 99) == 0);
            reset     = ($urandom_range(0, 399) == 0);
            cycle();
        end
        reset = 1'b0; scan_done = 1'b0; read_fifo = 1'b0; core_valid = '0;

        // Four cores: ptr=2 with cores 1 and 3 requesting picks core 3, then 1.
        @(posedge clock); #1;
        reset4 = 1'b0;
        valid4 = 4'b0010; index4 = {16'h0333, 16'h0222, 16'h0111, 16'h0000};
        @(negedge clock);
        chk("c4_seed", ready4, 4'b0010);
        @(posedge clock); #1;
        valid4 = 4'b1010;
        @(negedge clock);
        chk("c4_first", ready4, 4'b1000);
        @(posedge clock); #1;
        valid4 = 4'b0010;
        @(negedge clock);
        chk("c4_second", ready4, 4'b0010);
        chk("c4_head", head4, 16'h0111);
        @(posedge clock); #1;
        valid4 = 4'b0000;
        @(negedge clock);
        chk("c4_count", count4, 16'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
